// File: rtl/fpu_operand_normalizer_if.sv
// Handshake and result bundle between the operand normalizer and its producer/consumer.
// The slave side is the normalizer; the master side feeds operands and drains results.
interface fpu_operand_normalizer_if #(
  parameter int EXP_W = 10
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic             out_a_sign;
  logic             out_b_sign;
  logic [EXP_W-1:0] out_a_exp;
  logic [EXP_W-1:0] out_b_exp;
  logic [23:0]      out_a_mant;
  logic [23:0]      out_b_mant;
  logic [31:0]      out_a_packed;
  logic [31:0]      out_b_packed;
  logic             out_a_uflow;
  logic             out_b_uflow;
  logic [2:0]       out_class_a;
  logic [2:0]       out_class_b;
  logic [1:0]       out_special;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid,
    input  out_a_sign, out_b_sign, out_a_exp, out_b_exp,
    input  out_a_mant, out_b_mant, out_a_packed, out_b_packed,
    input  out_a_uflow, out_b_uflow, out_class_a, out_class_b, out_special
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid,
    output out_a_sign, out_b_sign, out_a_exp, out_b_exp,
    output out_a_mant, out_b_mant, out_a_packed, out_b_packed,
    output out_a_uflow, out_b_uflow, out_class_a, out_class_b, out_special
  );
endinterface

// File: rtl/fpu_operand_normalizer.sv
// Divider front end: classifies two IEEE-754 singles, normalizes subnormals one bit per
// cycle so the divider always sees a hidden 1, and predicts the special-case quotient.
module fpu_operand_normalizer #(
  parameter int EXP_W           = 10,
  parameter bit FLUSH_SUBNORMAL = 1'b0
) (
  input logic                   clk,
  input logic                   rst,
  fpu_operand_normalizer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_SUB    = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } cls_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [23:0]      mant;
    cls_t             cls;
  } op_t;

  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  state_t     state;
  state_t     state_next;
  op_t        op_a;
  op_t        op_b;
  logic [1:0] special;
  logic       need_a;
  logic       need_b;

  // A subnormal starts at exponent 1 with no hidden bit; flushing turns it into signed zero.
  function automatic op_t load_op(input logic [31:0] raw);
    op_t op;
    op.sign = raw[31];
    op.expo = {{(EXP_W-8){1'b0}}, raw[30:23]};
    op.mant = {raw[30:23] != 8'd0, raw[22:0]};
    op.cls  = CLS_NORMAL;
    if (raw[30:23] == 8'd0) begin
      if ((raw[22:0] == 23'd0) || FLUSH_SUBNORMAL) begin
        op.cls  = CLS_ZERO;
        op.mant = '0;
      end else begin
        op.cls  = CLS_SUB;
        op.expo = EXP_ONE;
      end
    end else if (raw[30:23] == 8'hFF) begin
      op.cls = (raw[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
    end
    return op;
  endfunction

  function automatic logic [1:0] predict(input cls_t ca, input cls_t cb);
    logic [1:0] res;
    res = 2'b00;
    if ((ca == CLS_NAN) || (cb == CLS_NAN) ||
        ((ca == CLS_ZERO) && (cb == CLS_ZERO)) ||
        ((ca == CLS_INF) && (cb == CLS_INF))) begin
      res = 2'b01;
    end else if ((ca == CLS_INF) || (cb == CLS_ZERO)) begin
      res = 2'b10;
    end else if ((ca == CLS_ZERO) || (cb == CLS_INF)) begin
      res = 2'b11;
    end
    return res;
  endfunction

  assign need_a = (op_a.cls == CLS_SUB) && !op_a.mant[23];
  assign need_b = (op_b.cls == CLS_SUB) && !op_b.mant[23];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid) state_next = NORM;
      NORM: if (!need_a && !need_b) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands shift independently; the shorter one simply idles until the longer finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      special <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a    <= load_op(bus.in_a);
            op_b    <= load_op(bus.in_b);
            special <= predict(load_op(bus.in_a).cls, load_op(bus.in_b).cls);
          end
        end
        NORM: begin
          if (need_a) begin
            op_a.mant <= {op_a.mant[22:0], 1'b0};
            op_a.expo <= op_a.expo - EXP_ONE;
          end
          if (need_b) begin
            op_b.mant <= {op_b.mant[22:0], 1'b0};
            op_b.expo <= op_b.expo - EXP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = (state == DONE);
  assign bus.out_a_sign   = op_a.sign;
  assign bus.out_b_sign   = op_b.sign;
  assign bus.out_a_exp    = op_a.expo;
  assign bus.out_b_exp    = op_b.expo;
  assign bus.out_a_mant   = op_a.mant;
  assign bus.out_b_mant   = op_b.mant;
  assign bus.out_a_packed = {op_a.sign, op_a.expo[7:0], op_a.mant[22:0]};
  assign bus.out_b_packed = {op_b.sign, op_b.expo[7:0], op_b.mant[22:0]};
  // Only a normalized subnormal can fall below exponent 1; zero packs correctly as-is.
  assign bus.out_a_uflow  = (op_a.cls == CLS_SUB) && ($signed(op_a.expo) < $signed(EXP_ONE));
  assign bus.out_b_uflow  = (op_b.cls == CLS_SUB) && ($signed(op_b.expo) < $signed(EXP_ONE));
  assign bus.out_class_a  = op_a.cls;
  assign bus.out_class_b  = op_b.cls;
  assign bus.out_special  = special;

endmodule

// File: tb/tb_fpu_operand_normalizer.sv
// Directed bench for the operand normalizer: hand-computed vectors, backpressure and
// mid-normalization reset.
module tb_fpu_operand_normalizer;

  localparam int EXP_W = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fpu_operand_normalizer_if #(.EXP_W(EXP_W)) bus ();

  fpu_operand_normalizer #(
    .EXP_W(EXP_W),
    .FLUSH_SUBNORMAL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // lat counts rising edges from the accepting edge (inclusive) to the one raising out_valid.
  typedef struct packed {
    logic [31:0] a, b, lat, sa, sb, ea, eb, ma, mb, pa, pb, ua, ub, ca, cb, sp;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] sext(input logic [EXP_W-1:0] e);
    return 32'($signed(e));
  endfunction

  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               output int lat);
    checkOutput({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while ((bus.out_valid !== 1'b1) && (lat < 40)) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseOutput(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, " in_ready after release"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, " out_valid after release"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic runVector(input int i);
    vec_t  v;
    int    lat;
    string t;
    v = vecs[i];
    t = $sformatf("v%0d", i);
    applyStimulus(t, v.a, v.b, lat);
    checkOutput({t, " latency"}, 32'(lat), v.lat);
    checkOutput({t, " sign_a"}, 32'(bus.out_a_sign), v.sa);
    checkOutput({t, " sign_b"}, 32'(bus.out_b_sign), v.sb);
    checkOutput({t, " exp_a"}, sext(bus.out_a_exp), v.ea);
    checkOutput({t, " exp_b"}, sext(bus.out_b_exp), v.eb);
    if (v.ca < 32'd3) checkOutput({t, " mant_a"}, 32'(bus.out_a_mant), v.ma);
    if (v.cb < 32'd3) checkOutput({t, " mant_b"}, 32'(bus.out_b_mant), v.mb);
    checkOutput({t, " packed_a"}, bus.out_a_packed, v.pa);
    checkOutput({t, " packed_b"}, bus.out_b_packed, v.pb);
    checkOutput({t, " uflow_a"}, 32'(bus.out_a_uflow), v.ua);
    checkOutput({t, " uflow_b"}, 32'(bus.out_b_uflow), v.ub);
    checkOutput({t, " class_a"}, 32'(bus.out_class_a), v.ca);
    checkOutput({t, " class_b"}, 32'(bus.out_class_b), v.cb);
    checkOutput({t, " special"}, 32'(bus.out_special), v.sp);
    releaseOutput(t);
  endtask

  task automatic checkIdleCleared(input string tag);
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, " exp_a"}, sext(bus.out_a_exp), 32'd0);
    checkOutput({tag, " mant_a"}, 32'(bus.out_a_mant), 32'd0);
    checkOutput({tag, " packed_a"}, bus.out_a_packed, 32'd0);
    checkOutput({tag, " packed_b"}, bus.out_b_packed, 32'd0);
    checkOutput({tag, " uflow_a"}, 32'(bus.out_a_uflow), 32'd0);
    checkOutput({tag, " class_a"}, 32'(bus.out_class_a), 32'd0);
    checkOutput({tag, " class_b"}, 32'(bus.out_class_b), 32'd0);
    checkOutput({tag, " special"}, 32'(bus.out_special), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    //            a             b             lat  sa sb ea    eb    ma          mb          pa            pb            ua ub ca cb sp
    vecs[0]  = '{32'h40400000, 32'h3FC00000, 2,  0, 0, 128,  127,  32'hC00000, 32'hC00000, 32'h40400000, 32'h3FC00000, 0, 0, 2, 2, 0};
    vecs[1]  = '{32'h00000001, 32'h3F800000, 25, 0, 0, -22,  127,  32'h800000, 32'h800000, 32'h75000000, 32'h3F800000, 1, 0, 1, 2, 0};
    vecs[2]  = '{32'h00400000, 32'h00000002, 24, 0, 0, 0,    -21,  32'h800000, 32'h800000, 32'h00000000, 32'h75800000, 1, 1, 1, 1, 0};
    vecs[3]  = '{32'h00000000, 32'h00000000, 2,  0, 0, 0,    0,    32'h000000, 32'h000000, 32'h00000000, 32'h00000000, 0, 0, 0, 0, 1};
    vecs[4]  = '{32'h3F800000, 32'h00000000, 2,  0, 0, 127,  0,    32'h800000, 32'h000000, 32'h3F800000, 32'h00000000, 0, 0, 2, 0, 2};
    vecs[5]  = '{32'h3F800000, 32'h7F800000, 2,  0, 0, 127,  255,  32'h800000, 32'h000000, 32'h3F800000, 32'h7F800000, 0, 0, 2, 3, 3};
    vecs[6]  = '{32'h7FC00000, 32'h3F800000, 2,  0, 0, 255,  127,  32'h000000, 32'h800000, 32'h7FC00000, 32'h3F800000, 0, 0, 4, 2, 1};
    vecs[7]  = '{32'h7F800000, 32'h7F800000, 2,  0, 0, 255,  255,  32'h000000, 32'h000000, 32'h7F800000, 32'h7F800000, 0, 0, 3, 3, 1};
    vecs[8]  = '{32'hBF800000, 32'h80000000, 2,  1, 1, 127,  0,    32'h800000, 32'h000000, 32'hBF800000, 32'h80000000, 0, 0, 2, 0, 2};
    vecs[9]  = '{32'h00000000, 32'h00000001, 25, 0, 0, 0,    -22,  32'h000000, 32'h800000, 32'h00000000, 32'h75000000, 0, 1, 0, 1, 3};
    vecs[10] = '{32'h7F800000, 32'h00000000, 2,  0, 0, 255,  0,    32'h000000, 32'h000000, 32'h7F800000, 32'h00000000, 0, 0, 3, 0, 2};
    vecs[11] = '{32'h00000000, 32'h7FC00001, 2,  0, 0, 0,    255,  32'h000000, 32'h000000, 32'h00000000, 32'h7FC00001, 0, 0, 0, 4, 1};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdleCleared("reset");

    for (int i = 0; i < 12; i++) runVector(i);

    // Backpressure: DONE holds while out_ready is low and new operands are refused.
    applyStimulus("bp", 32'h40400000, 32'h3FC00000, lat);
    checkOutput("bp latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("bp%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      checkOutput($sformatf("bp%0d packed_a", k), bus.out_a_packed, 32'h40400000);
      checkOutput($sformatf("bp%0d packed_b", k), bus.out_b_packed, 32'h3FC00000);
    end
    bus.in_valid = 1'b0;
    releaseOutput("bp");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp no stray result", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a long normalization must discard it entirely.
    bus.in_a     = 32'h00000001;
    bus.in_b     = 32'h3F800000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midrst in_ready during norm", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdleCleared("midrst");
    repeat (25) @(posedge clk);
    #1;
    checkOutput("midrst no result", 32'(bus.out_valid), 32'd0);
    runVector(0);
    runVector(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
